// File: rtl/guess_entry.sv
// Button front end for the ntermo game: synchronise, debounce and edge-detect four
// push-buttons, then edit three 3-bit guess digits under a cursor and strobe ENTER.
module guess_entry #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_INC,
  input  logic       BTN_DEC,
  input  logic       BTN_NEXT,
  input  logic       BTN_ENTER,
  output logic [2:0] N0,
  output logic [2:0] N1,
  output logic [2:0] N2,
  output logic       ENTER,
  output logic [1:0] CURSOR
);

  // The counter never needs to hold more than DEBOUNCE_CYCLES-1.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [3:0] btn_raw;
  logic [3:0] event_w;

  assign btn_raw = {BTN_ENTER, BTN_NEXT, BTN_DEC, BTN_INC};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic          sync1_q, sync1_d;
      logic          sync2_q, sync2_d;
      logic          deb_q, deb_d;
      logic          prev_q, prev_d;
      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        sync1_d = btn_raw[gi];
        sync2_d = sync1_q;
        deb_d   = deb_q;
        prev_d  = deb_q;
        cnt_d   = '0;
        if (sync2_q != deb_q) begin
          if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge CLK) begin
        if (RESET) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          deb_q   <= 1'b0;
          prev_q  <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= sync1_d;
          sync2_q <= sync2_d;
          deb_q   <= deb_d;
          prev_q  <= prev_d;
          cnt_q   <= cnt_d;
        end
      end

      assign event_w[gi] = deb_q & ~prev_q;
    end
  endgenerate

  logic       ev_inc, ev_dec, ev_next, ev_enter;
  logic [2:0][2:0] digit_q, digit_d;
  logic [1:0] cursor_q, cursor_d;
  logic       enter_q, enter_d;

  assign {ev_enter, ev_next, ev_dec, ev_inc} = event_w;

  always_comb begin
    digit_d  = digit_q;
    cursor_d = cursor_q;
    enter_d  = 1'b0;
    if (ev_enter) begin
      enter_d  = 1'b1;
      cursor_d = 2'd0;
    end else if (cursor_q == 2'd3) begin
      cursor_d = 2'd0;
    end else begin
      // Edits land on the pre-advance cursor even when NEXT fires in the same cycle.
      for (int i = 0; i < 3; i++) begin
        if (cursor_q == 2'(i)) begin
          if (ev_inc && !ev_dec) begin
            digit_d[i] = digit_q[i] + 3'd1;
          end else if (ev_dec && !ev_inc) begin
            digit_d[i] = digit_q[i] - 3'd1;
          end
        end
      end
      if (ev_next) begin
        cursor_d = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      digit_q  <= '0;
      cursor_q <= 2'd0;
      enter_q  <= 1'b0;
    end else begin
      digit_q  <= digit_d;
      cursor_q <= cursor_d;
      enter_q  <= enter_d;
    end
  end

  assign N0     = digit_q[0];
  assign N1     = digit_q[1];
  assign N2     = digit_q[2];
  assign ENTER  = enter_q;
  assign CURSOR = cursor_q;

endmodule

// File: tb/tb_guess_entry.sv
// Bench for guess_entry: directed button presses, a window-based behavioural model
// checked every cycle, and literal checkpoints taken from the test scenarios.
module tb_guess_entry;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0000;   // {enter, next, dec, inc}
  logic [2:0] n0, n1, n2;
  logic       enter;
  logic [1:0] cursor;

  int total = 0;
  int bad = 0;
  int enter_pulses = 0;

  guess_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLK(clk), .RESET(rst),
    .BTN_INC(btn[0]), .BTN_DEC(btn[1]), .BTN_NEXT(btn[2]), .BTN_ENTER(btn[3]),
    .N0(n0), .N1(n1), .N2(n2), .ENTER(enter), .CURSOR(cursor)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a button's accepted level flips once its last DB synchronised samples all
  // disagree with it; an event is the cycle after the accepted level rises.
  int m_sync1 [4];
  int m_s [4];
  int m_d [4];
  int m_dprev [4];
  int m_hist [4][DB];
  int m_n [3];
  int m_cur;
  int m_enter;

  always @(posedge clk) begin
    int ev [4];
    int all_diff;
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        m_sync1[b] = 0; m_s[b] = 0; m_d[b] = 0; m_dprev[b] = 0;
        for (int k = 0; k < DB; k++) m_hist[b][k] = 0;
      end
      for (int i = 0; i < 3; i++) m_n[i] = 0;
      m_cur = 0;
      m_enter = 0;
    end else begin
      for (int b = 0; b < 4; b++) ev[b] = (m_d[b] == 1 && m_dprev[b] == 0) ? 1 : 0;
      m_enter = 0;
      if (ev[3] == 1) begin
        m_enter = 1;
        m_cur = 0;
      end else begin
        if (ev[0] == 1 && ev[1] == 0) m_n[m_cur] = (m_n[m_cur] + 1) % 8;
        if (ev[1] == 1 && ev[0] == 0) m_n[m_cur] = (m_n[m_cur] + 7) % 8;
        if (ev[2] == 1) m_cur = (m_cur + 1) % 3;
      end
      for (int b = 0; b < 4; b++) begin
        m_dprev[b] = m_d[b];
        for (int k = DB - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
        m_hist[b][0] = m_s[b];
        all_diff = 1;
        for (int k = 0; k < DB; k++) if (m_hist[b][k] == m_d[b]) all_diff = 0;
        if (all_diff == 1) m_d[b] = m_s[b];
        m_s[b] = m_sync1[b];
        m_sync1[b] = int'(btn[b]);
      end
    end
    #1;
    check("model_N0", int'(n0), m_n[0]);
    check("model_N1", int'(n1), m_n[1]);
    check("model_N2", int'(n2), m_n[2]);
    check("model_CURSOR", int'(cursor), m_cur);
    check("model_ENTER", int'(enter), m_enter);
    if (enter) enter_pulses++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    btn = mask;
    cyc(hold);
    btn = 4'b0000;
    cyc(12);
  endtask

  initial begin
    int pulses_before;
    cyc(3);
    check("reset_N0", int'(n0), 0);
    check("reset_CURSOR", int'(cursor), 0);
    check("reset_ENTER", int'(enter), 0);
    rst = 1'b0;
    cyc(2);

    // Three INC, one NEXT, two DEC.
    repeat (3) press(4'b0001, 10);
    press(4'b0100, 10);
    repeat (2) press(4'b0010, 10);
    check("seq_N0", int'(n0), 3);
    check("seq_N1", int'(n1), 6);
    check("seq_N2", int'(n2), 0);
    check("seq_CURSOR", int'(cursor), 1);
    check("seq_no_enter", enter_pulses, 0);

    // Wrap-around at 7 and cursor cycling.
    repeat (2) press(4'b0100, 10);
    repeat (4) press(4'b0001, 10);
    check("pre_wrap_N0", int'(n0), 7);
    press(4'b0001, 10);
    check("inc_wrap_N0", int'(n0), 0);
    press(4'b0010, 10);
    check("dec_wrap_N0", int'(n0), 7);
    press(4'b0100, 10);
    check("cur_step1", int'(cursor), 1);
    press(4'b0100, 10);
    check("cur_step2", int'(cursor), 2);
    press(4'b0100, 10);
    check("cur_step3", int'(cursor), 0);

    // ENTER held 20 cycles: single pulse right after e6.
    pulses_before = enter_pulses;
    btn = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      check($sformatf("enter_e%0d", i), int'(enter), (i == 6) ? 1 : 0);
    end
    @(negedge clk);
    btn = 4'b0000;
    cyc(15);
    check("enter_one_pulse", enter_pulses - pulses_before, 1);
    check("enter_CURSOR", int'(cursor), 0);
    check("enter_N0", int'(n0), 7);
    check("enter_N1", int'(n1), 6);

    // Glitches of three cycles are ignored; four stable cycles give one increment.
    btn = 4'b0001; cyc(3); btn = 4'b0000; cyc(3);
    btn = 4'b0001; cyc(3); btn = 4'b0000; cyc(12);
    check("glitch_N0", int'(n0), 7);
    press(4'b0001, 4);
    check("clean4_N0", int'(n0), 0);

    // Coincident events.
    press(4'b0011, 10);
    check("incdec_N0", int'(n0), 0);
    press(4'b0101, 10);
    check("incnext_N0", int'(n0), 1);
    check("incnext_CURSOR", int'(cursor), 1);
    pulses_before = enter_pulses;
    press(4'b1001, 10);
    check("enterinc_pulse", enter_pulses - pulses_before, 1);
    check("enterinc_N1", int'(n1), 6);
    check("enterinc_CURSOR", int'(cursor), 0);

    // Reset mid-press: the interrupted NEXT count must not complete.
    btn = 4'b0100; cyc(3);
    rst = 1'b1; cyc(1);
    rst = 1'b0; cyc(2);
    btn = 4'b0000; cyc(12);
    check("rst_mid_N0", int'(n0), 0);
    check("rst_mid_N1", int'(n1), 0);
    check("rst_mid_CURSOR", int'(cursor), 0);

    // INC held through reset is a fresh press landing at e6.
    btn = 4'b0001;
    rst = 1'b1; cyc(2);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #2;
      check($sformatf("held_rst_e%0d", i), int'(n0), (i >= 6) ? 1 : 0);
    end
    @(negedge clk);
    btn = 4'b0000;
    cyc(12);
    check("held_rst_final", int'(n0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
